// File: rtl/bias_array_if.sv
// Bus bundle between the systolic column outputs, the bias stage and the
// activation stage. The stage drives the outputs; the upstream source drives
// the inputs.
interface bias_array_if #(
    parameter int NUM_COLS = 2,
    parameter int DATA_W   = 16,
    parameter int ROW_W    = 8
);
    logic [NUM_COLS*DATA_W-1:0] bias_scalar_in;
    logic [NUM_COLS-1:0]        bias_load_in;
    logic [NUM_COLS*DATA_W-1:0] bias_sys_data_in;
    logic [NUM_COLS-1:0]        bias_sys_valid_in;
    logic                       bias_bypass_in;
    logic [ROW_W-1:0]           bias_rows_in;
    logic                       bias_sat_clr_in;
    logic [NUM_COLS*DATA_W-1:0] bias_z_data_out;
    logic [NUM_COLS-1:0]        bias_Z_valid_out;
    logic [NUM_COLS-1:0]        bias_col_done_out;
    logic                       bias_all_done_out;
    logic [NUM_COLS-1:0]        bias_sat_flag_out;

    modport master (
        output bias_scalar_in, bias_load_in, bias_sys_data_in, bias_sys_valid_in,
        output bias_bypass_in, bias_rows_in, bias_sat_clr_in,
        input  bias_z_data_out, bias_Z_valid_out, bias_col_done_out,
        input  bias_all_done_out, bias_sat_flag_out
    );

    modport slave (
        input  bias_scalar_in, bias_load_in, bias_sys_data_in, bias_sys_valid_in,
        input  bias_bypass_in, bias_rows_in, bias_sat_clr_in,
        output bias_z_data_out, bias_Z_valid_out, bias_col_done_out,
        output bias_all_done_out, bias_sat_flag_out
    );
endinterface

// File: rtl/bias_array.sv
// Per-column bias add stage: one bias register per column, 1-cycle registered
// datapath with optional saturation or bypass, sticky saturation flags and
// per-column row counters that signal batch and tile completion.
module bias_array #(
    parameter int NUM_COLS = 2,
    parameter int DATA_W   = 16,
    parameter int SATURATE = 1,
    parameter int ROW_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    bias_array_if.slave    bif
);
    localparam logic SAT_EN = (SATURATE != 0);

    // Signed add in DATA_W+1 bits; returns {saturation_hit, result}.
    function automatic logic [DATA_W:0] add_clamp(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              sat_en
    );
        logic [DATA_W:0] sum;
        logic [DATA_W:0] ret;
        sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (sat_en && (sum[DATA_W] != sum[DATA_W-1])) begin
            if (sum[DATA_W]) begin
                ret = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                ret = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            ret = {1'b0, sum[DATA_W-1:0]};
        end
        return ret;
    endfunction

    logic [NUM_COLS*DATA_W-1:0] bias_q,      bias_d;
    logic [NUM_COLS*DATA_W-1:0] z_data_q,    z_data_d;
    logic [NUM_COLS-1:0]        z_valid_q,   z_valid_d;
    logic [NUM_COLS-1:0]        col_done_q,  col_done_d;
    logic                       all_done_q,  all_done_d;
    logic [NUM_COLS-1:0]        sat_flag_q,  sat_flag_d;
    logic [NUM_COLS-1:0]        pending_q,   pending_d;
    logic [ROW_W-1:0]           row_cnt_q [NUM_COLS];
    logic [ROW_W-1:0]           row_cnt_d [NUM_COLS];

    logic [DATA_W-1:0]          din_s    [NUM_COLS];
    logic [DATA_W:0]            add_s    [NUM_COLS];
    logic [DATA_W-1:0]          sample_s [NUM_COLS];
    logic [NUM_COLS-1:0]        hit_s;
    logic [ROW_W-1:0]           cnt_inc_s [NUM_COLS];
    logic [NUM_COLS-1:0]        pend_all_s;

    // Next-state for bias registers, datapath, flags, counters and done pulses.
    always_comb begin
        bias_d     = bias_q;
        z_data_d   = z_data_q;
        z_valid_d  = {NUM_COLS{1'b0}};
        col_done_d = {NUM_COLS{1'b0}};
        sat_flag_d = sat_flag_q;
        hit_s      = {NUM_COLS{1'b0}};
        for (int c = 0; c < NUM_COLS; c++) begin
            din_s[c]     = bif.bias_sys_data_in[c*DATA_W +: DATA_W];
            add_s[c]     = add_clamp(din_s[c], bias_q[c*DATA_W +: DATA_W], SAT_EN);
            sample_s[c]  = din_s[c];
            cnt_inc_s[c] = row_cnt_q[c] + {{(ROW_W-1){1'b0}}, 1'b1};
            row_cnt_d[c] = row_cnt_q[c];

            // A sample in the load cycle still sees the old bias (bias_q).
            if (bif.bias_load_in[c]) begin
                bias_d[c*DATA_W +: DATA_W] = bif.bias_scalar_in[c*DATA_W +: DATA_W];
            end else begin
                bias_d[c*DATA_W +: DATA_W] = bias_q[c*DATA_W +: DATA_W];
            end

            if (bif.bias_bypass_in) begin
                sample_s[c] = din_s[c];
                hit_s[c]    = 1'b0;
            end else begin
                sample_s[c] = add_s[c][DATA_W-1:0];
                hit_s[c]    = add_s[c][DATA_W];
            end

            z_valid_d[c] = bif.bias_sys_valid_in[c];
            if (bif.bias_sys_valid_in[c]) begin
                z_data_d[c*DATA_W +: DATA_W] = sample_s[c];
            end else begin
                z_data_d[c*DATA_W +: DATA_W] = z_data_q[c*DATA_W +: DATA_W];
            end

            // A new saturation event beats a simultaneous clear.
            if (bif.bias_sys_valid_in[c] && hit_s[c]) begin
                sat_flag_d[c] = 1'b1;
            end else if (bif.bias_sat_clr_in) begin
                sat_flag_d[c] = 1'b0;
            end else begin
                sat_flag_d[c] = sat_flag_q[c];
            end

            // Equality compare with natural wrap keeps a mid-batch change of R from hanging.
            if (bif.bias_rows_in == {ROW_W{1'b0}}) begin
                row_cnt_d[c] = {ROW_W{1'b0}};
            end else if (bif.bias_sys_valid_in[c]) begin
                if (cnt_inc_s[c] == bif.bias_rows_in) begin
                    row_cnt_d[c]  = {ROW_W{1'b0}};
                    col_done_d[c] = 1'b1;
                end else begin
                    row_cnt_d[c]  = cnt_inc_s[c];
                end
            end else begin
                row_cnt_d[c] = row_cnt_q[c];
            end
        end

        pend_all_s = pending_q | col_done_d;
        all_done_d = 1'b0;
        if (bif.bias_rows_in == {ROW_W{1'b0}}) begin
            pending_d = {NUM_COLS{1'b0}};
        end else if (&pend_all_s) begin
            pending_d  = {NUM_COLS{1'b0}};
            all_done_d = 1'b1;
        end else begin
            pending_d  = pend_all_s;
        end
    end

    // State and registered outputs; asynchronous active-low reset abandons any batch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_q     <= '0;
            z_data_q   <= '0;
            z_valid_q  <= '0;
            col_done_q <= '0;
            all_done_q <= 1'b0;
            sat_flag_q <= '0;
            pending_q  <= '0;
            for (int c = 0; c < NUM_COLS; c++) begin
                row_cnt_q[c] <= '0;
            end
        end else begin
            bias_q     <= bias_d;
            z_data_q   <= z_data_d;
            z_valid_q  <= z_valid_d;
            col_done_q <= col_done_d;
            all_done_q <= all_done_d;
            sat_flag_q <= sat_flag_d;
            pending_q  <= pending_d;
            for (int c = 0; c < NUM_COLS; c++) begin
                row_cnt_q[c] <= row_cnt_d[c];
            end
        end
    end

    assign bif.bias_z_data_out   = z_data_q;
    assign bif.bias_Z_valid_out  = z_valid_q;
    assign bif.bias_col_done_out = col_done_q;
    assign bif.bias_all_done_out = all_done_q;
    assign bif.bias_sat_flag_out = sat_flag_q;

endmodule

// File: doc/bias_array.md
Name: bias_array

Overview:
- Parametrised N-column bias stage sitting between the systolic array's column outputs and the activation stage.
- Each column holds its own bias register and adds that bias to every valid pre-activation sample on its column, with optional saturation and a bypass mode.
- Per-column row counters raise done pulses when a batch of rows has drained, and an aggregate pulse marks the whole tile complete.

Parameters:
- NUM_COLS, 2, number of feature columns.
- DATA_W, 16, signed fixed-point width of data and bias (Q8.8 at default).
- SATURATE, 1, 1 = clamp sums to the signed range; 0 = two's-complement wrap.
- ROW_W, 8, width of the row-count configuration and the internal counters.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- bias_scalar_in  in  NUM_COLS*DATA_W  bias values from the unified buffer; column c occupies bits [c*DATA_W +: DATA_W].
- bias_load_in  in  NUM_COLS  per-column bias register load strobe.
- bias_sys_data_in  in  NUM_COLS*DATA_W  systolic column outputs, same packing as bias_scalar_in.
- bias_sys_valid_in  in  NUM_COLS  per-column sample valid.
- bias_bypass_in  in  1  1 = pass data through without adding bias.
- bias_rows_in  in  ROW_W  rows per batch; 0 disables done tracking.
- bias_sat_clr_in  in  1  clears all sticky saturation flags.
- bias_z_data_out  out  NUM_COLS*DATA_W  biased samples.
- bias_Z_valid_out  out  NUM_COLS  per-column output valid.
- bias_col_done_out  out  NUM_COLS  one-cycle pulse per column at the end of its batch.
- bias_all_done_out  out  1  one-cycle pulse when every column has finished the current batch.
- bias_sat_flag_out  out  NUM_COLS  sticky per-column saturation indicator.

Behaviour:
- Reset (rst low, asynchronous): all of the following clear to 0:
  - bias registers, bias_z_data_out, bias_Z_valid_out
  - bias_col_done_out, bias_all_done_out, bias_sat_flag_out
  - row counters and pending-done bits
- Reset mid-batch abandons the batch; no done pulse is issued for it.
- Bias load: when bias_load_in[c]=1 at a clock edge, bias_reg[c] takes the new value.
  - A sample arriving in the same cycle uses the OLD bias.
  - The new bias applies from the next sample onward.
- Datapath latency: exactly 1 cycle.
  - If bias_sys_valid_in[c] is high at edge t, bias_Z_valid_out[c] is high and bias_z_data_out slice c is valid after edge t.
  - Valid is not registered-held: with no input valid, bias_Z_valid_out[c]=0 and the data slice holds its last value.
  - Columns are fully independent; any valid pattern is legal, with no back-pressure.
- Arithmetic:
  - sum = sign-extended data + sign-extended bias in DATA_W+1 bits.
  - SATURATE=1: sum > 2^(DATA_W-1)-1 outputs max positive (0x7FFF); sum < -2^(DATA_W-1) outputs min negative (0x8000). Either case sets bias_sat_flag_out[c].
  - SATURATE=0: output is the low DATA_W bits; the flag is never set.
- Bypass: bias_bypass_in=1 gives output = input, same 1-cycle latency, no saturation, bias registers untouched.
- Saturation flags: bias_sat_clr_in clears all flags. If a clear and a new saturation event occur in the same cycle, set wins.
- Row counting (bias_rows_in = R ≠ 0), per column:
  - The counter increments on each accepted sample.
  - When the sample that makes the count reach R is accepted, the counter returns to 0 and bias_col_done_out[c] pulses in the same cycle as that sample's bias_Z_valid_out.
  - Each column pulse also sets pending_done[c].
  - When all pending_done bits are set (including ones set in this cycle), bias_all_done_out pulses for one cycle coincident with the final column's pulse, and all pending bits clear.
  - A column may start its next batch before the others finish. A second done on an already-pending column keeps pending set and does not double-count.
- R=0: no counting, no done pulses; counters and pending bits hold at 0.
- Changing bias_rows_in mid-batch is illegal; the result is unspecified but must not hang: the counter compares with equality and wraps at 2^ROW_W.

Test Plan:
- Load: bias 0x0100 to col0 and 0xFF00 to col1, then send 0x0280 on both → one cycle later col0=0x0380, col1=0x0180, valid=2'b11.
- Same-cycle load and sample on col0: old bias 0x0100, new bias 0x0200, data 0x0000 → output 0x0100; the next sample 0x0000 gives 0x0200.
- Saturation, SATURATE=1: data 0x7F00 + bias 0x0200 → 0x7FFF and sat_flag[0]=1; data 0x8100 + bias 0xFE00 → 0x8000. Assert sat_clr → flags clear. With SATURATE=0, the first case gives 0x8100.
- Row counting with R=3: col0 receives 3 consecutive samples, col1 receives 3 samples delayed by 2 cycles → col_done[0] pulses with col0's third output, col_done[1] and all_done pulse together with col1's third output.
- Bypass: bias=0x0100, bypass=1, data 0x1234 → output 0x1234 after 1 cycle, sat flag unchanged.
- Reset asserted after 2 of 3 rows: all outputs 0 immediately; after release, 3 new samples → exactly one col_done pulse.
